// File: rtl/gpio_cfg_deserializer.sv
// PS GPIO control-bus front end: synchronise, detect serial-clock edges,
// shift sdata into config registers and commit them on a trigger edge.
module gpio_cfg_deserializer #(
  parameter int GPIO_W = 16,
  parameter int CFG_W  = 256,
  parameter int SEL_W  = 16,
  parameter int AVG_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [SEL_W-1:0]  sel_out,
  output logic [CFG_W-1:0]  cycle_count_out,
  output logic [CFG_W-1:0]  adc_cycle_count_out,
  output logic [AVG_W-1:0]  adc_num_avg_out,
  output logic [CFG_W-1:0]  pre_delay_out,
  output logic [CFG_W-1:0]  post_delay_out,
  output logic              mux_set_out,
  output logic              mask_enable_out,
  output logic              shift_data,
  output logic              mask_shift_en,
  output logic              locking_shift_en,
  output logic              trigger_pulse,
  output logic              pl_rst_req
);

  localparam int NB      = 13;
  localparam int B_SDATA = 0;
  localparam int B_MASK  = 1;
  localparam int B_SEL   = 2;
  localparam int B_CC    = 3;
  localparam int B_MUX   = 4;
  localparam int B_PLRST = 5;
  localparam int B_TRIG  = 6;
  localparam int B_AVG   = 7;
  localparam int B_ACC   = 8;
  localparam int B_PRE   = 9;
  localparam int B_POST  = 10;
  localparam int B_LOCK  = 11;
  localparam int B_MEN   = 12;

  logic [NB-1:0] s1_q, s2_q, p_q;
  logic [NB-1:0] rise;
  logic          d;

  assign rise = s2_q & ~p_q;
  assign d    = s2_q[B_SDATA];

  // Lines 13+ carry nothing for this block.
  logic unused_bits;
  assign unused_bits = ^{gpio_in[GPIO_W-1:NB],
                         rise[B_SDATA], rise[B_PLRST]};

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CFG_W-1:0] cc_q, cc_d;
  logic [CFG_W-1:0] acc_q, acc_d;
  logic [AVG_W-1:0] avg_q, avg_d;
  logic [CFG_W-1:0] pre_q, pre_d;
  logic [CFG_W-1:0] post_q, post_d;
  logic             mux_q, mux_d;
  logic             men_q, men_d;

  always_comb begin
    sel_d  = sel_q;
    cc_d   = cc_q;
    acc_d  = acc_q;
    avg_d  = avg_q;
    pre_d  = pre_q;
    post_d = post_q;
    mux_d  = mux_q;
    men_d  = men_q;
    if (rise[B_SEL])  sel_d  = {sel_q[SEL_W-2:0], d};
    if (rise[B_CC])   cc_d   = {cc_q[CFG_W-2:0], d};
    if (rise[B_ACC])  acc_d  = {acc_q[CFG_W-2:0], d};
    if (rise[B_AVG])  avg_d  = {avg_q[AVG_W-2:0], d};
    if (rise[B_PRE])  pre_d  = {pre_q[CFG_W-2:0], d};
    if (rise[B_POST]) post_d = {post_q[CFG_W-2:0], d};
    if (rise[B_MUX])  mux_d  = d;
    if (rise[B_MEN])  men_d  = d;
  end

  logic [SEL_W-1:0] sel_o_q;
  logic [CFG_W-1:0] cc_o_q, acc_o_q;
  logic [AVG_W-1:0] avg_o_q;
  logic [CFG_W-1:0] pre_o_q, post_o_q;
  logic             mux_o_q, men_o_q;
  logic             sd_q, mask_q, lock_q;
  logic             trig_q, pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      p_q      <= '0;
      sel_q    <= '0;
      cc_q     <= '0;
      acc_q    <= '0;
      avg_q    <= '0;
      pre_q    <= '0;
      post_q   <= '0;
      mux_q    <= 1'b0;
      men_q    <= 1'b0;
      sel_o_q  <= '0;
      cc_o_q   <= '0;
      acc_o_q  <= '0;
      avg_o_q  <= '0;
      pre_o_q  <= '0;
      post_o_q <= '0;
      mux_o_q  <= 1'b0;
      men_o_q  <= 1'b0;
      sd_q     <= 1'b0;
      mask_q   <= 1'b0;
      lock_q   <= 1'b0;
      trig_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      s1_q   <= gpio_in[NB-1:0];
      s2_q   <= s1_q;
      p_q    <= s2_q;
      sel_q  <= sel_d;
      cc_q   <= cc_d;
      acc_q  <= acc_d;
      avg_q  <= avg_d;
      pre_q  <= pre_d;
      post_q <= post_d;
      mux_q  <= mux_d;
      men_q  <= men_d;
      sd_q   <= d;
      mask_q <= rise[B_MASK];
      lock_q <= rise[B_LOCK];
      trig_q <= rise[B_TRIG];
      pulse_q <= trig_q;
      // Commit takes the pre-shift value of a coincident shift.
      if (rise[B_TRIG]) begin
        sel_o_q  <= sel_q;
        cc_o_q   <= cc_q;
        acc_o_q  <= acc_q;
        avg_o_q  <= avg_q;
        pre_o_q  <= pre_q;
        post_o_q <= post_q;
        mux_o_q  <= mux_q;
        men_o_q  <= men_q;
      end
    end
  end

  assign sel_out             = sel_o_q;
  assign cycle_count_out     = cc_o_q;
  assign adc_cycle_count_out = acc_o_q;
  assign adc_num_avg_out     = avg_o_q;
  assign pre_delay_out       = pre_o_q;
  assign post_delay_out      = post_o_q;
  assign mux_set_out         = mux_o_q;
  assign mask_enable_out     = men_o_q;
  assign shift_data          = sd_q;
  assign mask_shift_en       = mask_q;
  assign locking_shift_en    = lock_q;
  assign trigger_pulse       = pulse_q;
  assign pl_rst_req          = s2_q[B_PLRST];

endmodule

// File: tb/tb_gpio_cfg_deserializer.sv
// Directed bench for gpio_cfg_deserializer: table of shift/commit
// records plus hand sequences for timing, overflow and corner cases.
module tb_gpio_cfg_deserializer;
  localparam int GPIO_W = 16;
  localparam int CFG_W  = 256;
  localparam int SEL_W  = 16;
  localparam int AVG_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [GPIO_W-1:0] gpio;
  logic [SEL_W-1:0]  sel_out;
  logic [CFG_W-1:0]  cc_out, acc_out, pre_out, post_out;
  logic [AVG_W-1:0]  avg_out;
  logic              mux_out, men_out;
  logic              sdata, mask_en, lock_en, tpulse, plrst;

  gpio_cfg_deserializer #(
    .GPIO_W(GPIO_W), .CFG_W(CFG_W),
    .SEL_W(SEL_W), .AVG_W(AVG_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .gpio_in             (gpio),
    .sel_out             (sel_out),
    .cycle_count_out     (cc_out),
    .adc_cycle_count_out (acc_out),
    .adc_num_avg_out     (avg_out),
    .pre_delay_out       (pre_out),
    .post_delay_out      (post_out),
    .mux_set_out         (mux_out),
    .mask_enable_out     (men_out),
    .shift_data          (sdata),
    .mask_shift_en       (mask_en),
    .locking_shift_en    (lock_en),
    .trigger_pulse       (tpulse),
    .pl_rst_req          (plrst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tp_cnt = 0;
  int mask_cnt = 0;
  int lock_cnt = 0;
  logic [31:0] mask_bits = '0;

  always @(negedge clk) begin
    if (tpulse === 1'b1) tp_cnt++;
    if (mask_en === 1'b1) begin
      mask_cnt++;
      mask_bits = {mask_bits[30:0], sdata};
    end
    if (lock_en === 1'b1) lock_cnt++;
  end

  task automatic chk(string name, logic [CFG_W-1:0] act,
                     logic [CFG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sbit(int line, logic b);
    gpio[0] = b;
    gpio[line] = 1'b1;
    tick(4);
    gpio[line] = 1'b0;
    tick(4);
  endtask

  task automatic commit();
    gpio[6] = 1'b1;
    tick(4);
    gpio[6] = 1'b0;
    tick(8);
  endtask

  function automatic logic [CFG_W-1:0] get_out(int line);
    logic [CFG_W-1:0] r;
    r = '0;
    case (line)
      2:  r = CFG_W'(sel_out);
      3:  r = cc_out;
      4:  r = CFG_W'(mux_out);
      7:  r = CFG_W'(avg_out);
      8:  r = acc_out;
      9:  r = pre_out;
      10: r = post_out;
      12: r = CFG_W'(men_out);
      default: r = '0;
    endcase
    return r;
  endfunction

  typedef struct {
    string            name;
    int               line;
    int               nbits;
    logic [31:0]      data;
    logic [CFG_W-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int tp0, m0, l0;
    logic stable;
    logic [15:0] selv;

    vecs[0] = '{"sel_a5c3", 2, 16, 32'hA5C3, 256'hA5C3};
    vecs[1] = '{"avg_dead", 7, 32, 32'hDEADBEEF, 256'hDEADBEEF};
    vecs[2] = '{"acc_20b", 8, 20, 32'hABCDE, 256'hABCDE};
    vecs[3] = '{"cc_12b", 3, 12, 32'h5A5, 256'h5A5};
    vecs[4] = '{"mux_1", 4, 1, 32'h1, 256'h1};
    vecs[5] = '{"men_1", 12, 1, 32'h1, 256'h1};
    vecs[6] = '{"mux_0", 4, 1, 32'h0, 256'h0};

    rst = 1'b1;
    gpio = '0;
    tick(3);
    rst = 1'b0;
    tp0 = tp_cnt; m0 = mask_cnt; l0 = lock_cnt;
    tick(20);
    chk("rst_sel", CFG_W'(sel_out), '0);
    chk("rst_cc", cc_out, '0);
    chk("rst_acc", acc_out, '0);
    chk("rst_avg", CFG_W'(avg_out), '0);
    chk("rst_pre", pre_out, '0);
    chk("rst_post", post_out, '0);
    chk("rst_bits", CFG_W'({mux_out, men_out, plrst}), '0);
    chk("rst_strobes", CFG_W'({tp_cnt - tp0, mask_cnt - m0,
        lock_cnt - l0}), '0);

    // Shift 0x0008, then check exact commit/pulse timing.
    selv = 16'h0008;
    stable = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      sbit(2, selv[i]);
      if (sel_out !== '0) stable = 1'b0;
    end
    chk("sel_stable_shift", CFG_W'(stable), 1);
    gpio[6] = 1'b1;
    tick(1);
    chk("trig_t1_pulse", CFG_W'(tpulse), 0);
    tick(1);
    chk("trig_t2_sel_old", CFG_W'(sel_out), 0);
    tick(1);
    chk("trig_t3_sel_new", CFG_W'(sel_out), 256'h8);
    chk("trig_t3_pulse", CFG_W'(tpulse), 0);
    tick(1);
    chk("trig_t4_pulse", CFG_W'(tpulse), 1);
    tick(1);
    chk("trig_t5_pulse", CFG_W'(tpulse), 0);
    gpio[6] = 1'b0;
    tick(8);

    for (int v = 0; v < 7; v++) begin
      for (int i = vecs[v].nbits - 1; i >= 0; i--)
        sbit(vecs[v].line, vecs[v].data[i]);
      commit();
      chk(vecs[v].name, get_out(vecs[v].line), vecs[v].exp);
    end
    chk("sel_kept", CFG_W'(sel_out), 256'hA5C3);

    // 260 alternating bits starting at 1; top 4 drop off.
    for (int i = 0; i < 260; i++)
      sbit(3, logic'((i + 1) % 2));
    commit();
    chk("cc_overflow", cc_out, {128{2'b10}});

    for (int i = 0; i < 8; i++) begin
      gpio[0] = 1'b1;
      gpio[9] = 1'b1;
      gpio[10] = 1'b1;
      tick(4);
      gpio[9] = 1'b0;
      gpio[10] = 1'b0;
      tick(4);
    end
    commit();
    chk("pre_simul", pre_out, 256'hFF);
    chk("post_simul", post_out, 256'hFF);
    gpio[0] = 1'b1;
    gpio[9] = 1'b1;
    gpio[6] = 1'b1;
    tick(4);
    gpio[9] = 1'b0;
    gpio[6] = 1'b0;
    tick(8);
    chk("pre_coinc_commit", pre_out, 256'hFF);
    commit();
    chk("pre_next_commit", pre_out, 256'h1FF);
    chk("post_unchanged", post_out, 256'hFF);

    m0 = mask_cnt; l0 = lock_cnt;
    sbit(1, 1'b1);
    sbit(1, 1'b0);
    sbit(1, 1'b1);
    sbit(1, 1'b1);
    sbit(1, 1'b0);
    chk("mask_count", CFG_W'(mask_cnt - m0), 5);
    chk("mask_data", CFG_W'(mask_bits[4:0]), 256'h16);
    chk("lock_idle", CFG_W'(lock_cnt - l0), 0);
    m0 = mask_cnt;
    sbit(11, 1'b1);
    sbit(11, 1'b0);
    chk("lock_count", CFG_W'(lock_cnt - l0), 2);
    chk("mask_idle", CFG_W'(mask_cnt - m0), 0);

    gpio[5] = 1'b1;
    tick(2);
    chk("plrst_high", CFG_W'(plrst), 1);
    tick(4);
    chk("plrst_no_clear", CFG_W'(sel_out), 256'hA5C3);
    gpio[5] = 1'b0;
    tick(3);
    chk("plrst_low", CFG_W'(plrst), 0);

    // Reset lands while a cycle_count clock is high.
    for (int i = 0; i < 100; i++) sbit(3, 1'b1);
    gpio[0] = 1'b1;
    gpio[3] = 1'b1;
    tick(1);
    rst = 1'b1;
    gpio = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("midrst_cc", cc_out, '0);
    chk("midrst_sel", CFG_W'(sel_out), '0);
    chk("midrst_pre", pre_out, '0);
    sbit(3, 1'b1);
    sbit(3, 1'b0);
    sbit(3, 1'b1);
    commit();
    chk("midrst_cc_5", cc_out, 256'h5);

    tp0 = tp_cnt;
    gpio[6] = 1'b1;
    tick(50);
    gpio[6] = 1'b0;
    tick(8);
    chk("trig_held_one", CFG_W'(tp_cnt - tp0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
